// File: rtl/fifo_sample_unpacker_if.sv
// Byte-read port toward the capture FIFO and the sample stream toward the consumer.
// master = unpacker side, slave = FIFO / downstream side.
interface fifo_sample_unpacker_if;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned SAMPLE_W = 10;

    logic                fifo_read_fifoen;
    logic                fifo_read_fifoempty;
    logic [BYTE_W-1:0]   fifo_read_data;
    logic [SAMPLE_W-1:0] sample_o;
    logic                sample_valid_o;
    logic                sample_ready_i;
    logic                trig_o;

    modport master (
        output fifo_read_fifoen,
        input  fifo_read_fifoempty,
        input  fifo_read_data,
        output sample_o,
        output sample_valid_o,
        input  sample_ready_i,
        output trig_o
    );

    modport slave (
        input  fifo_read_fifoen,
        output fifo_read_fifoempty,
        output fifo_read_data,
        input  sample_o,
        input  sample_valid_o,
        output sample_ready_i,
        input  trig_o
    );
endinterface

// File: rtl/fifo_sample_unpacker.sv
// Reads 4 bytes per capture word from the FIFO byte port, rebuilds the big-endian word
// and streams its three 10-bit samples, marking the trigger sample once per transfer.
module fifo_sample_unpacker #(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned WORDCNT_W  = 24
) (
    input  logic                   fifo_read_fifoclk,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [WORDCNT_W-1:0]   words_i,
    fifo_sample_unpacker_if.master bus,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [WORDCNT_W-1:0]   words_done_o
);
    localparam int unsigned LAT_W    = 2;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned SAMPLE_W = 10;
    localparam int unsigned CNT_W1   = WORDCNT_W + 1;
    localparam logic [LAT_W-1:0] LAT_END = LAT_W'(RD_LATENCY);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t                r_state,      w_state_nxt;
    logic [WORD_W-1:0]     r_word,       w_word_nxt;
    logic [WORDCNT_W-1:0]  r_words,      w_words_nxt;
    logic [WORDCNT_W-1:0]  r_words_done, w_words_done_nxt;
    logic [1:0]            r_byte_idx,   w_byte_idx_nxt;
    logic [1:0]            r_smp_idx,    w_smp_idx_nxt;
    logic [LAT_W-1:0]      r_lat_cnt,    w_lat_cnt_nxt;
    logic                  r_trig_seen,  w_trig_seen_nxt;
    logic                  r_fifoen,     w_fifoen_nxt;
    logic [SAMPLE_W-1:0]   r_sample,     w_sample_nxt;
    logic                  r_valid,      w_valid_nxt;
    logic                  r_trig,       w_trig_nxt;
    logic                  r_busy,       w_busy_nxt;
    logic                  r_done,       w_done_nxt;

    logic [WORD_W-1:0]     w_word_shift;
    logic                  w_accept;
    logic [CNT_W1-1:0]     w_words_inc;
    logic [WORDCNT_W-1:0]  w_words_done_sat;

    function automatic logic [SAMPLE_W-1:0] f_field(input logic [WORD_W-1:0] word,
                                                    input logic [1:0]        idx);
        case (idx)
            2'd0:    return word[9:0];
            2'd1:    return word[19:10];
            default: return word[29:20];
        endcase
    endfunction

    // mergeloc 2'b11 is a pre-trigger word; otherwise it names the trigger sample index
    function automatic logic f_trig(input logic [WORD_W-1:0] word,
                                    input logic [1:0]        idx,
                                    input logic              seen);
        return !seen && (word[31:30] != 2'b11) && (word[31:30] == idx);
    endfunction

    assign w_word_shift     = {r_word[WORD_W-BYTE_W-1:0], bus.fifo_read_data};
    assign w_accept         = r_valid && bus.sample_ready_i;
    assign w_words_inc      = {1'b0, r_words_done} + CNT_W1'(1);
    assign w_words_done_sat = w_words_inc[WORDCNT_W] ? r_words_done
                                                     : w_words_inc[WORDCNT_W-1:0];

    always_comb begin
        w_state_nxt      = r_state;
        w_word_nxt       = r_word;
        w_words_nxt      = r_words;
        w_words_done_nxt = r_words_done;
        w_byte_idx_nxt   = r_byte_idx;
        w_smp_idx_nxt    = r_smp_idx;
        w_lat_cnt_nxt    = r_lat_cnt;
        w_trig_seen_nxt  = r_trig_seen;
        w_fifoen_nxt     = 1'b0;
        w_sample_nxt     = r_sample;
        w_valid_nxt      = r_valid;
        w_trig_nxt       = r_trig;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    w_words_nxt      = words_i;
                    w_words_done_nxt = '0;
                    w_byte_idx_nxt   = 2'd0;
                    w_trig_seen_nxt  = 1'b0;
                    w_state_nxt      = (words_i == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (!bus.fifo_read_fifoempty) begin
                    w_fifoen_nxt  = 1'b1;
                    w_lat_cnt_nxt = '0;
                    w_state_nxt   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // lat_cnt reaches RD_LATENCY in the cycle the requested byte is valid
                if (r_lat_cnt == LAT_END) begin
                    w_word_nxt = w_word_shift;
                    if (r_byte_idx == 2'd3) begin
                        w_byte_idx_nxt = 2'd0;
                        w_smp_idx_nxt  = 2'd0;
                        w_valid_nxt    = 1'b1;
                        w_sample_nxt   = f_field(w_word_shift, 2'd0);
                        w_trig_nxt     = f_trig(w_word_shift, 2'd0, r_trig_seen);
                        w_state_nxt    = ST_EMIT;
                    end else begin
                        w_byte_idx_nxt = 2'(r_byte_idx + 2'd1);
                        w_state_nxt    = ST_REQ;
                    end
                end else begin
                    w_lat_cnt_nxt = LAT_W'(r_lat_cnt + LAT_W'(1));
                end
            end
            ST_EMIT: begin
                if (w_accept) begin
                    if (r_trig) begin
                        w_trig_seen_nxt = 1'b1;
                    end
                    if (r_smp_idx == 2'd2) begin
                        w_valid_nxt      = 1'b0;
                        w_trig_nxt       = 1'b0;
                        w_words_done_nxt = w_words_done_sat;
                        w_state_nxt      = (w_words_inc == {1'b0, r_words}) ? ST_DONE : ST_REQ;
                    end else begin
                        w_smp_idx_nxt = 2'(r_smp_idx + 2'd1);
                        w_sample_nxt  = f_field(r_word, 2'(r_smp_idx + 2'd1));
                        w_trig_nxt    = f_trig(r_word, 2'(r_smp_idx + 2'd1),
                                               r_trig_seen || r_trig);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_REQ) || (w_state_nxt == ST_WAIT) ||
                     (w_state_nxt == ST_EMIT);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge fifo_read_fifoclk) begin
        if (reset_i) begin
            r_state      <= ST_IDLE;
            r_word       <= '0;
            r_words      <= '0;
            r_words_done <= '0;
            r_byte_idx   <= 2'd0;
            r_smp_idx    <= 2'd0;
            r_lat_cnt    <= '0;
            r_trig_seen  <= 1'b0;
            r_fifoen     <= 1'b0;
            r_sample     <= '0;
            r_valid      <= 1'b0;
            r_trig       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_word       <= w_word_nxt;
            r_words      <= w_words_nxt;
            r_words_done <= w_words_done_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
            r_smp_idx    <= w_smp_idx_nxt;
            r_lat_cnt    <= w_lat_cnt_nxt;
            r_trig_seen  <= w_trig_seen_nxt;
            r_fifoen     <= w_fifoen_nxt;
            r_sample     <= w_sample_nxt;
            r_valid      <= w_valid_nxt;
            r_trig       <= w_trig_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign bus.fifo_read_fifoen = r_fifoen;
    assign bus.sample_o         = r_sample;
    assign bus.sample_valid_o   = r_valid;
    assign bus.trig_o           = r_trig;
    assign busy_o               = r_busy;
    assign done_o               = r_done;
    assign words_done_o         = r_words_done;

endmodule
